avmm_cmd_master: RTL and testbench

- Avalon-MM host that drives the qsys register slaves (PIO outputs such as sample-count and threshold registers) from a simple command stream.
- Commands arrive from the Ethernet command parser as single read or write requests. Each one becomes exactly one Avalon-MM transfer, and each one produces exactly one response word back to the packet builder.
- Handles waitrequest, enforces a bus timeout, and keeps transaction and error counters for status readback.

---
 rtl/avmm_cmd_master.sv | 122 ++++++++++++
 tb/tb_avmm_cmd_master.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/avmm_cmd_master.sv
// Avalon-MM host: turns single read/write commands into one bus transfer and one response word.
// Min latency cmd accept -> rsp_valid is 2 cycles; one transfer in flight, cmd_ready low until the response handshakes.
module avmm_cmd_master #(
   parameter int          ADDR_W  = 16,
   parameter int          DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_write,
   output logic              rsp_error,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_waitrequest,
   output logic [15:0]       txn_count,
   output logic [7:0]        err_count
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   // Abort fires on the edge where the counter already holds TIMEOUT-1,
   // so a strobe is never high for more than TIMEOUT cycles.
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        accept, done, abort;
   logic [31:0] to_cnt;
   logic [15:0] txn_q;
   logic [7:0]  err_q;

   assign txn_count = txn_q;
   assign err_count = err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (!avm_waitrequest) begin
               done      = 1'b1;
               state_nxt = RESP;
            end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
               abort     = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_write     <= 1'b0;
         rsp_error     <= 1'b0;
         avm_address   <= '0;
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_writedata <= '0;
         to_cnt        <= '0;
         txn_q         <= '0;
         err_q         <= '0;
      end else begin
         cmd_ready <= (state_nxt == IDLE);
         rsp_valid <= (state_nxt == RESP);
         if (accept) begin
            avm_address   <= cmd_addr;
            avm_writedata <= cmd_wdata;
            avm_write     <= cmd_write;
            avm_read      <= ~cmd_write;
            rsp_write     <= cmd_write;
            to_cnt        <= '0;
         end
         if (done) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            rsp_rdata <= avm_read ? avm_readdata : '0;
            rsp_error <= 1'b0;
            txn_q     <= txn_q + 16'd1;
         end else if (abort) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
            txn_q     <= txn_q + 16'd1;
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
         end else if (state == ACCESS && avm_waitrequest) begin
            to_cnt <= to_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Directed bench for avmm_cmd_master (TIMEOUT = 4) with hand-computed expectations.
module tb_avmm_cmd_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
   logic [31:0] rsp_rdata;
   logic [15:0] avm_address;
   logic        avm_read, avm_write, avm_waitrequest;
   logic [31:0] avm_writedata, avm_readdata;
   logic [15:0] txn_count;
   logic [7:0]  err_count;

   int          n_pass = 0;
   int          n_total = 0;
   int          strobe_cyc;
   logic        bus_ok;
   logic [15:0] exp_txn;
   logic [7:0]  exp_err;

   always #5 clk = ~clk;

   avmm_cmd_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_write(rsp_write), .rsp_error(rsp_error),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
      .avm_waitrequest(avm_waitrequest),
      .txn_count(txn_count), .err_count(err_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Issues one command and plays the slave: waitrequest high for 'stall' strobe cycles.
   // Returns at the first negedge after the strobe drops.
   task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input int stall, input logic [31:0] rd);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      @(negedge clk);
      cmd_valid  = 1'b0;
      strobe_cyc = 0;
      bus_ok     = 1'b1;
      for (int k = 0; k < 64; k++) begin
         if (!(avm_read || avm_write)) break;
         if (avm_address !== a || avm_write !== w || avm_read !== ~w) bus_ok = 1'b0;
         if (w && avm_writedata !== d) bus_ok = 1'b0;
         avm_waitrequest = (k < stall);
         avm_readdata    = (k < stall) ? 32'hDEAD_BEEF : rd;
         strobe_cyc++;
         @(negedge clk);
      end
      avm_waitrequest = 1'b0;
      check("strobe_released", 32'(avm_read | avm_write), 0);
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_cleared", 32'(rsp_valid), 0);
      check("ready_back", 32'(cmd_ready), 1);
   endtask

   initial begin
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
      rsp_ready = 0; avm_readdata = 0; avm_waitrequest = 0;
      exp_txn = 0; exp_err = 0;

      #12;
      check("rst_cmd_ready", 32'(cmd_ready), 1);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_strobes", 32'({avm_read, avm_write}), 0);
      check("rst_addr", 32'(avm_address), 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_counts", 32'({txn_count, err_count}), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // zero-wait write
      issue(1'b1, 16'h0000, 32'h0000_ABCD, 0, 32'h0);
      exp_txn++;
      check("wr_bus", 32'(bus_ok), 1);
      check("wr_strobe_len", strobe_cyc, 1);
      check("wr_rsp_valid", 32'(rsp_valid), 1);
      check("wr_rsp_error", 32'(rsp_error), 0);
      check("wr_rsp_rdata", rsp_rdata, 0);
      check("wr_rsp_write", 32'(rsp_write), 1);
      check("wr_txn", 32'(txn_count), 32'(exp_txn));
      finish_rsp();

      // read with three stall cycles
      issue(1'b0, 16'h0000, 32'h0, 3, 32'h0000_000F);
      exp_txn++;
      check("rd_bus", 32'(bus_ok), 1);
      check("rd_strobe_len", strobe_cyc, 4);
      check("rd_rsp_valid", 32'(rsp_valid), 1);
      check("rd_rsp_rdata", rsp_rdata, 32'h0000_000F);
      check("rd_rsp_write", 32'(rsp_write), 0);
      check("rd_rsp_error", 32'(rsp_error), 0);
      finish_rsp();

      // response backpressure with a queued command
      issue(1'b0, 16'h0012, 32'h0, 1, 32'h1234_5678);
      exp_txn++;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0005; cmd_wdata = 32'h55;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid), 1);
         check("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
         check("bp_cmd_ready", 32'(cmd_ready), 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp_rsp_cleared", 32'(rsp_valid), 0);
      check("bp_ready_next", 32'(cmd_ready), 1);
      check("bp_no_early_strobe", 32'(avm_write), 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("bp_queued_strobe", 32'(avm_write), 1);
      check("bp_queued_addr", 32'(avm_address), 32'h0005);
      @(negedge clk);
      exp_txn++;
      check("bp_queued_rsp", 32'(rsp_valid), 1);
      finish_rsp();
      check("bp_txn", 32'(txn_count), 32'(exp_txn));

      // timeout: waitrequest stuck high
      issue(1'b0, 16'h0020, 32'h0, 1000, 32'h0);
      exp_txn++; exp_err++;
      check("to_bus", 32'(bus_ok), 1);
      check("to_strobe_len", strobe_cyc, 4);
      check("to_rsp_error", 32'(rsp_error), 1);
      check("to_rsp_rdata", rsp_rdata, 0);
      check("to_err", 32'(err_count), 32'(exp_err));
      finish_rsp();

      // repeated timeouts saturate err_count
      for (int i = 0; i < 300; i++) begin
         issue(1'b0, 16'h0021, 32'h0, 1000, 32'h0);
         exp_txn++;
         if (exp_err != 8'hFF) exp_err++;
         finish_rsp();
      end
      check("sat_err", 32'(err_count), 32'h00FF);
      check("sat_txn", 32'(txn_count), 32'(exp_txn));

      // txn_count wrap from a preloaded value
      @(negedge clk);
      force dut.txn_q = 16'hFFFD;
      @(negedge clk);
      release dut.txn_q;
      exp_txn = 16'hFFFD;
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, 16'h0030, 32'h0000_0100 + 32'(i), 0, 32'h0);
         exp_txn++;
         check("wrap_txn", 32'(txn_count), 32'(exp_txn));
         finish_rsp();
      end
      check("wrap_zero", 32'(txn_count), 0);
      check("wrap_err", 32'(err_count), 32'h00FF);

      // reset during a stalled write
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0007; cmd_wdata = 32'h77;
      avm_waitrequest = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("mid_strobe", 32'(avm_write), 1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_strobe", 32'(avm_write), 0);
      check("mid_rst_rsp", 32'(rsp_valid), 0);
      check("mid_rst_ready", 32'(cmd_ready), 1);
      check("mid_rst_counts", 32'({txn_count, err_count}), 0);
      @(negedge clk);
      reset_n = 1'b1;
      avm_waitrequest = 1'b0;
      issue(1'b1, 16'h0009, 32'h0000_0099, 0, 32'h0);
      check("post_bus", 32'(bus_ok), 1);
      check("post_strobe_len", strobe_cyc, 1);
      check("post_rsp_valid", 32'(rsp_valid), 1);
      check("post_txn", 32'(txn_count), 1);
      finish_rsp();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
